// File: rtl/ifu_pkg.sv
// Shared constants, types and FSM state encoding for the IFU miss path.
package ifu_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;

    typedef logic [ADDR_W-OFFSET_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        FILL      = 2'd3
    } ifu_miss_state_t;

endpackage

// File: rtl/ifu_victim_rr.sv
// Round-robin victim pointer for the fully associative I-cache.
// clr has priority over inc so an invalidate restarts replacement at entry 0.
module ifu_victim_rr #(
    parameter  int NUM_LINES = 8,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             Clock,
    input  logic             Rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] ptr
);

    // Advance one entry per fill, wrapping at NUM_LINES-1.
    always_ff @(posedge Clock) begin
        if (Rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == IDX_W'(NUM_LINES - 1)) ? '0 : ptr + IDX_W'(1);
        end
    end

endmodule

// File: rtl/ifu_miss_ctrl.sv
// IFU I-cache miss/refill controller.
// Hits return registered cache data one cycle after accept; misses fetch a
// line from memory, fill a round-robin victim and forward the line.
// Also sequences whole-cache invalidation after reset and on flush.
// Optional hit/miss counters: define IFU_MISS_CTRL_PERF_EN.
module ifu_miss_ctrl #(
    parameter  int NUM_LINES = 8,
    parameter  int LINE_W    = 128,
    parameter  int OFFSET_W  = 4,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 Clock,
    input  logic                 Rst,
    input  logic                 flush,
    input  logic                 fetch_req_valid,
    input  logic [31:0]          fetch_pc,
    output logic                 fetch_req_ready,
    input  logic                 lookup_hit,
    input  logic [LINE_W-1:0]    cache_line_in,
    output logic                 fetch_rsp_valid,
    output logic [LINE_W-1:0]    fetch_rsp_line,
    output logic                 mem_req_valid,
    output logic [31:0]          mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_rsp_valid,
    input  logic [LINE_W-1:0]    mem_rsp_data,
    output logic                 fill_valid,
    output logic [IDX_W-1:0]     fill_idx,
    output logic [31-OFFSET_W:0] fill_tag,
    output logic [LINE_W-1:0]    fill_data,
    output logic                 cache_inv_all,
    output logic                 busy,
    output logic                 spurious_rsp
`ifdef IFU_MISS_CTRL_PERF_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    import ifu_pkg::*;

    ifu_miss_state_t       state, state_nxt;
    logic [31-OFFSET_W:0]  line_addr;
    logic [LINE_W-1:0]     line_q;
    logic                  rsp_hit_q;
    logic                  flush_pend;
    logic                  spurious_q;
    logic                  acc;
    logic                  inv_fire;
    logic [IDX_W-1:0]      victim_ptr;

    // Byte offset within a line does not affect the miss path.
    logic unused_pc_bits;
    assign unused_pc_bits = ^fetch_pc[OFFSET_W-1:0];

    // Pending invalidate (post-reset or flush) blocks new requests until issued.
    assign fetch_req_ready = (state == IDLE) && !flush_pend && !flush;
    assign acc             = fetch_req_valid && fetch_req_ready;
    assign inv_fire        = (state == IDLE) && flush_pend && !Rst;

    assign cache_inv_all   = inv_fire;
    assign busy            = (state != IDLE);
    assign spurious_rsp    = spurious_q;
    assign mem_req_addr    = {line_addr, {OFFSET_W{1'b0}}};
    assign fill_idx        = victim_ptr;
    assign fill_tag        = line_addr;
    assign fill_data       = line_q;
    assign fetch_rsp_line  = line_q;
    // Hits complete only from IDLE, fills only from FILL, so no overlap.
    assign fetch_rsp_valid = rsp_hit_q || fill_valid;

    // State register.
    always_ff @(posedge Clock) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt     = state;
        mem_req_valid = 1'b0;
        fill_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (acc && !lookup_hit) state_nxt = MISS_REQ;
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) state_nxt = FILL;
            end
            FILL: begin
                fill_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Line address, line data, hit response, flush and error bookkeeping.
    // flush_pend comes out of reset set so the cache is invalidated once.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            line_addr  <= '0;
            line_q     <= '0;
            rsp_hit_q  <= 1'b0;
            flush_pend <= 1'b1;
            spurious_q <= 1'b0;
        end else begin
            rsp_hit_q <= acc && lookup_hit;
            if (acc && lookup_hit)  line_q    <= cache_line_in;
            if (acc && !lookup_hit) line_addr <= fetch_pc[31:OFFSET_W];
            if (state == MISS_WAIT && mem_rsp_valid) line_q <= mem_rsp_data;
            if (state != MISS_WAIT && mem_rsp_valid) spurious_q <= 1'b1;
            if (flush)         flush_pend <= 1'b1;
            else if (inv_fire) flush_pend <= 1'b0;
        end
    end

    ifu_victim_rr #(.NUM_LINES(NUM_LINES)) u_victim (
        .Clock (Clock),
        .Rst   (Rst),
        .clr   (inv_fire),
        .inc   (fill_valid),
        .ptr   (victim_ptr)
    );

`ifdef IFU_MISS_CTRL_PERF_EN
    // Saturating accepted-hit / accepted-miss counters; flush leaves them alone.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (acc && lookup_hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (acc && !lookup_hit && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_miss_ctrl.sv
// Self-checking bench for ifu_miss_ctrl: table of fetch vectors plus
// hand sequences for reset, flush, wrap, spurious response and abort.
module tb_ifu_miss_ctrl;

    localparam int NL = 8;

    logic         Clock = 1'b0;
    logic         Rst = 1'b1;
    logic         flush = 1'b0;
    logic         fetch_req_valid = 1'b0;
    logic [31:0]  fetch_pc = '0;
    logic         fetch_req_ready;
    logic         lookup_hit = 1'b0;
    logic [127:0] cache_line_in = '0;
    logic         fetch_rsp_valid;
    logic [127:0] fetch_rsp_line;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready = 1'b0;
    logic         mem_rsp_valid = 1'b0;
    logic [127:0] mem_rsp_data = '0;
    logic         fill_valid;
    logic [2:0]   fill_idx;
    logic [27:0]  fill_tag;
    logic [127:0] fill_data;
    logic         cache_inv_all;
    logic         busy;
    logic         spurious_rsp;
`ifdef IFU_MISS_CTRL_PERF_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    always #5 Clock = ~Clock;

    ifu_miss_ctrl #(.NUM_LINES(NL)) dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .flush           (flush),
        .fetch_req_valid (fetch_req_valid),
        .fetch_pc        (fetch_pc),
        .fetch_req_ready (fetch_req_ready),
        .lookup_hit      (lookup_hit),
        .cache_line_in   (cache_line_in),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_line  (fetch_rsp_line),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .fill_valid      (fill_valid),
        .fill_idx        (fill_idx),
        .fill_tag        (fill_tag),
        .fill_data       (fill_data),
        .cache_inv_all   (cache_inv_all),
        .busy            (busy),
        .spurious_rsp    (spurious_rsp)
`ifdef IFU_MISS_CTRL_PERF_EN
        ,
        .hit_cnt         (hit_cnt),
        .miss_cnt        (miss_cnt)
`endif
    );

    typedef struct {
        logic [127:0] line;
        logic         fill;
        logic [2:0]   idx;
        logic [27:0]  tag;
    } exp_t;

    typedef struct {
        logic         hit;
        logic [31:0]  pc;
        logic [127:0] line;
        int           rdy_dly;
        int           rsp_dly;
        logic         flush_wait;
        logic [31:0]  exp_addr;
        logic [27:0]  exp_tag;
    } vec_t;

    exp_t       sb[$];
    exp_t       mon_e;
    vec_t       vt[6];
    int         n_cmp = 0;
    int         n_err = 0;
    int         inv_seen = 0;
    logic [2:0] exp_vptr = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic hit, input logic [31:0] pc, input logic [127:0] line,
                                input int rd, input int sd, input logic fw,
                                input logic [31:0] ea, input logic [27:0] et);
        vec_t v;
        v.hit = hit; v.pc = pc; v.line = line; v.rdy_dly = rd; v.rsp_dly = sd;
        v.flush_wait = fw; v.exp_addr = ea; v.exp_tag = et;
        return v;
    endfunction

    // Response monitor: every response pops one expectation; fills must match it.
    always @(negedge Clock) begin
        if (!Rst) begin
            if (cache_inv_all) inv_seen++;
            if (fetch_rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rsp_unexpected: got line %0h expected no response", fetch_rsp_line);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_line", fetch_rsp_line, mon_e.line);
                    chk("fill_valid_with_rsp", fill_valid, mon_e.fill);
                    if (mon_e.fill) begin
                        chk("fill_idx", fill_idx, mon_e.idx);
                        chk("fill_tag", fill_tag, mon_e.tag);
                        chk("fill_data", fill_data, mon_e.line);
                    end
                end
            end else if (fill_valid) begin
                n_cmp++; n_err++;
                $display("FAIL fill_without_rsp: got fill_valid 1 expected 0");
            end
        end
    end

    // Issue one fetch; for misses act as the memory with the given delays.
    task automatic do_fetch(input vec_t v);
        int   t;
        exp_t e;
        fetch_pc        = v.pc;
        lookup_hit      = v.hit;
        cache_line_in   = v.hit ? v.line : ~v.line;
        fetch_req_valid = 1'b1;
        #1;
        t = 0;
        while (!fetch_req_ready && t < 20) begin
            @(posedge Clock); #1; t++;
        end
        if (!fetch_req_ready) begin
            chk("req_ready_timeout", fetch_req_ready, 1);
            fetch_req_valid = 1'b0;
            return;
        end
        e.line = v.line; e.fill = !v.hit; e.idx = exp_vptr; e.tag = v.exp_tag;
        sb.push_back(e);
        @(posedge Clock); #1;
        fetch_req_valid = 1'b0;
        lookup_hit      = 1'b0;
        if (v.hit) begin
            chk("hit_not_busy", busy, 0);
        end else begin
            exp_vptr = exp_vptr + 3'd1;
            for (int i = 0; i < v.rdy_dly; i++) begin
                chk("mem_req_valid_hold", mem_req_valid, 1);
                chk("mem_req_addr_hold", mem_req_addr, v.exp_addr);
                @(posedge Clock); #1;
            end
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_req_addr", mem_req_addr, v.exp_addr);
            mem_req_ready = 1'b1;
            @(posedge Clock); #1;
            mem_req_ready = 1'b0;
            chk("mem_req_drop", mem_req_valid, 0);
            chk("wait_busy", busy, 1);
            for (int i = 0; i < v.rsp_dly; i++) begin
                if (v.flush_wait && i == 0) flush = 1'b1;
                @(posedge Clock); #1;
                flush = 1'b0;
            end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.line;
            @(posedge Clock); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            chk("fill_cycle_busy", busy, 1);
            @(posedge Clock); #1;
            chk("idle_after_fill", busy, 0);
            chk("inv_after_fill", cache_inv_all, v.flush_wait);
            chk("ready_after_fill", fetch_req_ready, !v.flush_wait);
            if (v.flush_wait) exp_vptr = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(1, 32'h0000_1004, {16{8'hA5}},          0, 0, 0, 32'h0000_1000, 28'h0000100);
        vt[1] = mk(1, 32'h0000_1010, {4{32'h1234_5678}},   0, 0, 0, 32'h0000_1010, 28'h0000101);
        vt[2] = mk(0, 32'h0000_2008, {8{16'hDEAD}},        3, 2, 0, 32'h0000_2000, 28'h0000200);
        vt[3] = mk(1, 32'h0000_1020, {16{8'h5A}},          0, 0, 0, 32'h0000_1020, 28'h0000102);
        vt[4] = mk(0, 32'hFFFF_FFFC, {4{32'hCAFE_F00D}},   0, 0, 0, 32'hFFFF_FFF0, 28'hFFFFFFF);
        vt[5] = mk(1, 32'h0000_0000, {2{64'h0123_4567_89AB_CDEF}}, 0, 0, 0, 32'h0, 28'h0);

        // Reset state and the single post-reset invalidate.
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_rsp_valid", fetch_rsp_valid, 0);
        chk("rst_rsp_line", fetch_rsp_line, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_inv", cache_inv_all, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spurious_rsp, 0);
        chk("rst_ready", fetch_req_ready, 0);
        Rst = 1'b0;
        #1;
        chk("boot_inv", cache_inv_all, 1);
        chk("boot_ready", fetch_req_ready, 0);
        @(posedge Clock); #1;
        chk("boot_inv_done", cache_inv_all, 0);
        chk("boot_ready_up", fetch_req_ready, 1);
        chk("boot_inv_count", inv_seen, 1);

        // Table: back-to-back hits, delayed miss, zero-wait miss.
        foreach (vt[i]) do_fetch(vt[i]);

        // Flush in IDLE beats a concurrent request, then invalidates.
        flush = 1'b1;
        fetch_pc = 32'h0000_1004; lookup_hit = 1'b1; cache_line_in = {16{8'hA5}};
        fetch_req_valid = 1'b1;
        #1;
        chk("flush_beats_fetch", fetch_req_ready, 0);
        @(posedge Clock); #1;
        flush = 1'b0;
        chk("flush_inv", cache_inv_all, 1);
        chk("flush_inv_ready", fetch_req_ready, 0);
        exp_vptr = '0;
        do_fetch(vt[0]);

        // NUM_LINES+1 misses: victim index walks 0..7 then wraps to 0.
        for (int i = 0; i <= NL; i++) begin
            logic [31:0] pc;
            pc = 32'h0001_0000 + 32'(i) * 32'h10 + 32'h4;
            do_fetch(mk(0, pc, {4{32'(i) ^ 32'h600D_0000}}, i % 2, i % 3, 0,
                        32'h0001_0000 + 32'(i) * 32'h10, pc[31:4]));
        end

        // Flush while waiting for memory: fill completes, invalidate follows.
        do_fetch(mk(0, 32'h0004_0048, {8{16'hBEEF}}, 1, 2, 1, 32'h0004_0040, 28'h0004004));
        do_fetch(mk(0, 32'h0004_0050, {8{16'hF00D}}, 0, 0, 0, 32'h0004_0050, 28'h0004005));

        // Memory response outside MISS_WAIT is ignored and sticky-flagged.
        chk("spurious_clear", spurious_rsp, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'h5555_AAAA}};
        @(posedge Clock); #1;
        mem_rsp_valid = 1'b0;
        chk("spurious_no_busy", busy, 0);
        chk("spurious_set", spurious_rsp, 1);
        repeat (3) @(posedge Clock);
        #1;
        chk("spurious_sticky", spurious_rsp, 1);
        chk("spurious_ready", fetch_req_ready, 1);

        // Reset in the middle of a miss abandons it.
        fetch_pc = 32'h5000_0010; lookup_hit = 1'b0; fetch_req_valid = 1'b1;
        @(posedge Clock); #1;
        fetch_req_valid = 1'b0;
        chk("abort_req_up", mem_req_valid, 1);
        Rst = 1'b1;
        @(posedge Clock); #1;
        chk("abort_req_drop", mem_req_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_spurious_clr", spurious_rsp, 0);
        Rst = 1'b0;
        exp_vptr = '0;
        #1;
        chk("abort_boot_inv", cache_inv_all, 1);
        @(posedge Clock); #1;

        // Counter traffic: two hits and a miss.
        do_fetch(vt[0]);
        do_fetch(vt[1]);
        do_fetch(vt[2]);
`ifdef IFU_MISS_CTRL_PERF_EN
        chk("hit_cnt", hit_cnt, 2);
        chk("miss_cnt", miss_cnt, 1);
`endif

        repeat (2) @(posedge Clock);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_miss_ctrl.md
Name: ifu_miss_ctrl

Overview:
- Miss/refill controller for the IFU instruction cache, a fully associative store of 128-bit lines with tag = pc[31:4].
- Accepts fetch requests and returns hit data from the cache one cycle later.
- On a miss: issues a line read to memory, writes the returned line into a round-robin victim entry, and forwards the line to the fetcher.
- Also sequences whole-cache invalidation (flush, and once after reset).

Parameters:
- NUM_LINES, 8, number of cache entries (power of 2, at least 2).
- LINE_W, 128, line width in bits.
- OFFSET_W, 4, byte-offset bits per line.

Ports:
- Clock  in  1  clock
- Rst  in  1  synchronous active-high reset
- fetch_req_valid  in  1  fetch request; held stable until accepted
- fetch_pc  in  32  fetch address
- fetch_req_ready  out  1  request accepted this cycle (IDLE, no flush pending)
- lookup_hit  in  1  combinational cache tag-match result for fetch_pc
- cache_line_in  in  LINE_W  cache data for fetch_pc on hit
- fetch_rsp_valid  out  1  one-cycle pulse, line valid
- fetch_rsp_line  out  LINE_W  returned line
- mem_req_valid  out  1  memory line-read request
- mem_req_addr  out  32  line-aligned address {pc[31:4],4'b0}
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  memory data valid
- mem_rsp_data  in  LINE_W  memory line
- fill_valid  out  1  one-cycle write strobe to the cache
- fill_idx  out  $clog2(NUM_LINES)  victim entry
- fill_tag  out  32-OFFSET_W  tag written
- fill_data  out  LINE_W  line written
- cache_inv_all  out  1  one-cycle pulse: clear all valid bits
- busy  out  1  state != IDLE
- spurious_rsp  out  1  sticky: mem_rsp_valid seen outside MISS_WAIT

Behaviour:
- Reset:
  - State IDLE; victim_ptr=0; all outputs 0, including spurious_rsp and fetch_rsp_line.
  - cache_inv_all pulses in the first cycle after Rst deasserts. fetch_req_ready=0 in that cycle.
  - Reset mid-operation abandons the miss; mem_req_valid is 0 after that edge.
- States: IDLE, MISS_REQ, MISS_WAIT, FILL.
- IDLE, handshake fires (fetch_req_valid & fetch_req_ready):
  - Hit: next cycle fetch_rsp_valid=1 and fetch_rsp_line=registered cache_line_in. Stay IDLE, so back-to-back hits give one response per cycle.
  - Miss: latch pc[31:4] as line_addr; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr={line_addr,4'b0}, held stable until mem_req_ready.
  - On the ready edge, go to MISS_WAIT; mem_req_valid=0 from then.
- MISS_WAIT: on mem_rsp_valid, latch mem_rsp_data and go to FILL. Waits indefinitely.
- FILL, exactly one cycle:
  - fill_valid=1, fill_idx=victim_ptr, fill_tag=line_addr, fill_data=latched line.
  - fetch_rsp_valid=1 with the same line in the same cycle.
  - victim_ptr increments and wraps NUM_LINES-1 -> 0. Go to IDLE.
- Miss latency: accept -> MISS_REQ (1) -> memory handshake -> rsp -> FILL response. Minimum 3 cycles after accept with zero-wait memory.
- flush:
  - In IDLE: pulse cache_inv_all next cycle and reset victim_ptr=0. flush beats fetch_req_valid in the same cycle (fetch_req_ready=0).
  - When busy: set flush_pend. The current miss completes, including FILL and the response. The invalidate pulse follows in the first IDLE cycle; fetch_req_ready=0 until it has issued.
- mem_rsp_valid in any state other than MISS_WAIT: ignored, and spurious_rsp set (sticky until Rst).
- fetch_rsp_valid is never asserted in two sources in one cycle: hits only complete from IDLE, fills only from FILL.

Optional Feature:
- Macro: IFU_MISS_CTRL_PERF_EN.
- When defined, add outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Incremented on each accepted hit or miss respectively.
  - Saturate at 32'hFFFF_FFFF; cleared by Rst only, not by flush.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- ifu_pkg holds:
  - LINE_W, OFFSET_W, ADDR_W=32 constants;
  - the line_addr_t typedef (ADDR_W-OFFSET_W bits);
  - the ifu_miss_state_t enum {IDLE, MISS_REQ, MISS_WAIT, FILL}.
- One natural sub-module: ifu_victim_rr, the round-robin victim pointer with increment and clear inputs.
- The FSM, flush_pend and datapath registers stay in ifu_miss_ctrl.

Test Plan:
- Reset release -> cache_inv_all=1 for exactly 1 cycle; all other outputs 0, fetch_req_ready=0 then 1.
- pc=32'h0000_1004, lookup_hit=1, cache_line_in=128'hA5.. -> next cycle fetch_rsp_valid=1, line=128'hA5.., busy=0.
- pc=32'h0000_2008 miss; mem_req_ready delayed 3 cycles, rsp data 128'hDEAD.. ->
  - mem_req_addr=32'h0000_2000 stable during the wait;
  - FILL cycle: fill_idx=0, fill_tag=28'h0000200, fetch_rsp_line=128'hDEAD..
- NUM_LINES+1 consecutive misses -> fill_idx 0..7 then 0 (wrap).
- flush asserted during MISS_WAIT -> fill and response still occur; cache_inv_all pulses the cycle after FILL; next fill uses fill_idx=0.
- mem_rsp_valid pulsed in IDLE -> no state change, spurious_rsp=1 until Rst. With IFU_MISS_CTRL_PERF_EN, 2 hits + 1 miss -> hit_cnt=2, miss_cnt=1.
